mem_wb: RTL and testbench
=========================

# mem_wb

Pipeline register and write-back stage between the MEM stage and the register file write port of the five-stage MIPS32 core. It latches MEM results under the pipeline stall/flush protocol and performs big-endian load-data alignment, including the LWL/LWR merge. It drives the regfile write port (`we`/`waddr`/`wdata`) and the HI/LO write port, and it owns the LL bit used by LL/SC.

## Interface
Parameters:
- `DW`, 32, data width; HI/LO width.
- `AW`, 5, register address width.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `stall`  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled.
- `flush`  in  1  exception flush; kills the MEM instruction and clears the LL bit.
- `mem_wd`  in  AW  destination register.
- `mem_wreg`  in  1  register write request.
- `mem_wdata`  in  DW  non-load result.
- `mem_ld_type`  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `mem_ld_off`  in  2  byte offset, `addr[1:0]`.
- `mem_rdata`  in  DW  raw memory word.
- `mem_rt_old`  in  DW  old rt value, used for the LWL/LWR merge.
- `mem_whilo`, `mem_hi`, `mem_lo`  in  1/DW/DW  HI/LO write request and data.
- `mem_llbit_we`, `mem_llbit_value`  in  1/1  LL bit update (LL sets it, SC clears it).
- `wb_wd`, `wb_wreg`, `wb_wdata`  out  AW/1/DW  to regfile `waddr`/`we`/`wdata`.
- `wb_whilo`, `wb_hi`, `wb_lo`  out  1/DW/DW  to the HI/LO register.
- `llbit_o`  out  1  forwarded LL bit, consumed by MEM for SC.

## Operation
- Stage register update, evaluated on every rising edge, highest priority first:
  - `rst` → all stage fields 0.
  - `flush` → bubble (all fields 0).
  - `stall[4]=1`, `stall[5]=0` → bubble.
  - `stall[4]=0` → latch all `mem_*` inputs.
  - Otherwise → hold.
- A bubble must have `wb_wreg=0`, `wb_whilo=0` and LL-write-enable 0. No side effect may escape a bubble.
- `wb_wdata` is `load_align(ld_type, ld_off, rdata, rt_old)` when the latched `ld_type≠0`; otherwise it is the latched `wdata`.
- Alignment is big-endian. Offset 0 is bits 31:24. Sign/zero extension follows the LB/LBU and LH/LHU distinction.
  - LB/LBU: byte `rdata[31-8*off -: 8]`.
  - LH/LHU: off 0 → `rdata[31:16]`; off 2 → `rdata[15:0]`.
  - LW: whole word.
  - LWL, by offset:
    - off 0: `rdata`
    - off 1: `{rdata[23:0], rt[7:0]}`
    - off 2: `{rdata[15:0], rt[15:0]}`
    - off 3: `{rdata[7:0], rt[23:0]}`
  - LWR, by offset:
    - off 0: `{rt[31:8], rdata[31:24]}`
    - off 1: `{rt[31:16], rdata[31:16]}`
    - off 2: `{rt[31:24], rdata[31:8]}`
    - off 3: `rdata`
- Misaligned LH/LHU (odd offset) or LW (offset ≠ 0) forces `wb_wreg=0`. Upstream raises the exception; this block only suppresses the write.
- `wb_wreg` is passed through for `wd=0`; the regfile discards writes to r0.
- LL bit register `llbit_q`, updated on each edge, priority: `rst` → 0; `flush` → 0; latched LL-write-enable → latched value; else hold.
- `llbit_o = wb_llbit_we ? wb_llbit_value : llbit_q`. This is combinational forwarding, so an LL in WB is visible to an SC in MEM in the same cycle.

## Timing
- Latency is one cycle: MEM inputs present at edge N appear on `wb_*` from N+1.
- Alignment is combinational from the stage register. The `wb_wdata` path into the regfile is valid within the WB cycle.
- The regfile commits on edge N+2 (its own write edge).
- Under `stall[5]=1` all outputs are held stable for as many cycles as asserted. Writes are not repeated into a different register, and the LL bit is not double-applied: the hold re-applies the same value idempotently.
- Reset values: all outputs 0; `llbit_q=0`; `llbit_o=0`.
- When `flush` and stall arrive in the same cycle, `flush` wins.
- When `rst` and `flush` arrive in the same cycle, `rst` wins; the result is identical.
- Reset asserted while a held (stalled) instruction is in WB: that instruction is dropped on the next edge.

## Structure
- Shared package/defines:
  - `RegBus` and `RegAddrBus` widths.
  - `ld_type` encodings (`LD_NONE`…`LD_LWR`).
  - Stall bit indices (`STALL_MEM=4`, `STALL_WB=5`).
  - `ZeroWord`.
- One sub-module, `load_align`: purely combinational, with inputs `ld_type`, `off`, `rdata`, `rt_old` and outputs `data` and `misalign`. It is instantiated once on the registered fields.

## Test plan
- Reset and pass-through: `rst=1` for 2 cycles → all outputs 0. Then `mem_wd=3`, `wreg=1`, `wdata=0x1234_5678`, `ld_type=0` → next cycle `wb_wd=3`, `wb_wreg=1`, `wb_wdata=0x12345678`.
- Loads with `rdata=0x8899_AABB`:
  - LB off 1 → `0xFFFF_FF99`.
  - LBU off 1 → `0x0000_0099`.
  - LH off 2 → `0xFFFF_AABB`.
  - LWL off 2, `rt_old=0x1122_3344` → `0xAABB_3344`.
  - LWR off 1, same `rt_old` → `0x1122_8899`.
- Misaligned: LW off 1 or LH off 3 → `wb_wreg=0`, with other fields latched.
- Stalls:
  - `stall=6'b011111` for one cycle → WB bubble (`wb_wreg=0`, `wb_whilo=0`).
  - `stall=6'b111111` for 3 cycles → outputs held unchanged, then the next instruction advances.
- LL/SC: LL in WB (`llbit_we=1`, value 1) → `llbit_o=1` in the same cycle, `llbit_q=1` after the edge. Then `flush=1` → `llbit_q=0` and a bubble with the HI/LO write suppressed.
- Priority: `flush=1` together with `stall[4]=0` → bubble, not latch. `mem_whilo=1` with `hi=0xA`, `lo=0xB` → `wb_whilo=1`, `wb_hi=0xA`, `wb_lo=0xB` one cycle later.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, load-type encodings and stall-vector bit indices
// for the MEM/WB pipeline register and its load-alignment helper.
package mem_wb_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // Stall vector bit positions.
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_type_e;

endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: bundle between the MEM stage (master) and the MEM/WB stage
// (slave).
//   stall/flush          pipeline control into the stage
//   mem_*                MEM-stage results to be latched
//   wb_*                 regfile and HI/LO write ports out of the stage
//   llbit_o              forwarded LL bit back to MEM for SC
interface mem_wb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [5:0]    stall;
    logic          flush;

    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_ld_type;
    logic [1:0]    mem_ld_off;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_rt_old;
    logic          mem_whilo;
    logic [DW-1:0] mem_hi;
    logic [DW-1:0] mem_lo;
    logic          mem_llbit_we;
    logic          mem_llbit_value;

    logic [AW-1:0] wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic          wb_whilo;
    logic [DW-1:0] wb_hi;
    logic [DW-1:0] wb_lo;
    logic          llbit_o;

    modport master (
        output stall, flush,
        output mem_wd, mem_wreg, mem_wdata, mem_ld_type, mem_ld_off,
        output mem_rdata, mem_rt_old, mem_whilo, mem_hi, mem_lo,
        output mem_llbit_we, mem_llbit_value,
        input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, llbit_o
    );

    modport slave (
        input  stall, flush,
        input  mem_wd, mem_wreg, mem_wdata, mem_ld_type, mem_ld_off,
        input  mem_rdata, mem_rt_old, mem_whilo, mem_hi, mem_lo,
        input  mem_llbit_we, mem_llbit_value,
        output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, llbit_o
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// load_align: big-endian load-data alignment (purely combinational).
//   ld_type   load kind (LD_NONE..LD_LWR)
//   off       byte offset within the word, addr[1:0]
//   rdata     raw memory word
//   rt_old    previous rt value, merged by LWL/LWR
//   data      aligned / extended / merged result
//   misalign  high for odd-offset LH/LHU or non-zero-offset LW
module load_align
    import mem_wb_pkg::*;
(
    input  ld_type_e          ld_type,
    input  logic [1:0]        off,
    input  logic [RegBus-1:0] rdata,
    input  logic [RegBus-1:0] rt_old,
    output logic [RegBus-1:0] data,
    output logic              misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Offset 0 addresses the most significant byte.
    always_comb begin
        byte_v = '0;
        case (off)
            2'd0:    byte_v = rdata[31:24];
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
    end

    always_comb begin
        half_v = off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        data     = ZeroWord;
        misalign = 1'b0;
        case (ld_type)
            LD_LB:  data = {{24{byte_v[7]}}, byte_v};
            LD_LBU: data = {24'b0, byte_v};
            LD_LH: begin
                data     = {{16{half_v[15]}}, half_v};
                misalign = off[0];
            end
            LD_LHU: begin
                data     = {16'b0, half_v};
                misalign = off[0];
            end
            LD_LW: begin
                data     = rdata;
                misalign = (off != 2'd0);
            end
            LD_LWL: begin
                case (off)
                    2'd0:    data = rdata;
                    2'd1:    data = {rdata[23:0], rt_old[7:0]};
                    2'd2:    data = {rdata[15:0], rt_old[15:0]};
                    default: data = {rdata[7:0],  rt_old[23:0]};
                endcase
            end
            LD_LWR: begin
                case (off)
                    2'd0:    data = {rt_old[31:8],  rdata[31:24]};
                    2'd1:    data = {rt_old[31:16], rdata[31:16]};
                    2'd2:    data = {rt_old[31:24], rdata[31:8]};
                    default: data = rdata;
                endcase
            end
            default: data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register and write-back stage.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mem_wb_if slave: stall/flush control, mem_* inputs, wb_* regfile
//         and HI/LO write ports, llbit_o forwarded LL bit
// Latches MEM results under stall/flush, aligns load data, and owns the LL
// bit used by LL/SC.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);

    logic [AW-1:0] wd_q;
    logic          wreg_q;
    logic [DW-1:0] wdata_q;
    ld_type_e      ld_type_q;
    logic [1:0]    ld_off_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rt_old_q;
    logic          whilo_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          llbit_we_q;
    logic          llbit_value_q;
    logic          llbit_q;

    logic [DW-1:0] align_data;
    logic          align_misalign;

    // MEM stalled while WB is free: WB gets a bubble so nothing retires twice.
    // Both stalled: hold, so the held write re-applies idempotently.
    always_ff @(posedge clk) begin
        if (rst || bus.flush ||
            (bus.stall[STALL_MEM] && !bus.stall[STALL_WB])) begin
            wd_q          <= '0;
            wreg_q        <= 1'b0;
            wdata_q       <= '0;
            ld_type_q     <= LD_NONE;
            ld_off_q      <= '0;
            rdata_q       <= '0;
            rt_old_q      <= '0;
            whilo_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
        end else if (!bus.stall[STALL_MEM]) begin
            wd_q          <= bus.mem_wd;
            wreg_q        <= bus.mem_wreg;
            wdata_q       <= bus.mem_wdata;
            ld_type_q     <= ld_type_e'(bus.mem_ld_type);
            ld_off_q      <= bus.mem_ld_off;
            rdata_q       <= bus.mem_rdata;
            rt_old_q      <= bus.mem_rt_old;
            whilo_q       <= bus.mem_whilo;
            hi_q          <= bus.mem_hi;
            lo_q          <= bus.mem_lo;
            llbit_we_q    <= bus.mem_llbit_we;
            llbit_value_q <= bus.mem_llbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            llbit_q <= 1'b0;
        end else if (llbit_we_q) begin
            llbit_q <= llbit_value_q;
        end
    end

    load_align u_load_align (
        .ld_type  (ld_type_q),
        .off      (ld_off_q),
        .rdata    (rdata_q),
        .rt_old   (rt_old_q),
        .data     (align_data),
        .misalign (align_misalign)
    );

    assign bus.wb_wd    = wd_q;
    // Misaligned loads never write; the exception itself is raised upstream.
    assign bus.wb_wreg  = wreg_q & ~align_misalign;
    assign bus.wb_wdata = (ld_type_q != LD_NONE) ? align_data : wdata_q;
    assign bus.wb_whilo = whilo_q;
    assign bus.wb_hi    = hi_q;
    assign bus.wb_lo    = lo_q;
    // Forward an LL in WB so an SC in MEM sees it in the same cycle.
    assign bus.llbit_o  = llbit_we_q ? llbit_value_q : llbit_q;

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: scoreboard bench for mem_wb. A stimulus process drives one
// MEM-stage input set per cycle and pushes the expected WB-visible outputs
// from a behavioural model; a monitor pops and compares after each edge.
module tb_mem_wb;
    import mem_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_if #(.DW(32), .AW(5)) bus ();

    mem_wb #(.DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [2:0]  ld;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] rt;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
    } stim_t;

    // Expected WB-visible state; dc marks wdata as unspecified (misaligned).
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        dc;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic        llo;
    } exp_t;

    exp_t m;
    logic m_llbit;
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [31:0] ref_align(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] rd, input logic [31:0] rt);
        int unsigned sh;
        int unsigned rsh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] mask;
        sh  = 8 * off;
        rsh = 8 * (3 - off);
        b   = 8'((rd >> (24 - sh)) & 32'hFF);
        h   = 16'((rd >> (16 - 8 * (off & 2'd2))) & 32'hFFFF);
        mask = (64'd1 << sh) - 64'd1;
        case (t)
            3'd1:    return 32'($signed(b));
            3'd2:    return {24'd0, b};
            3'd3:    return 32'($signed(h));
            3'd4:    return {16'd0, h};
            3'd5:    return rd;
            3'd6:    return (rd << sh) | (rt & mask[31:0]);
            3'd7:    return (rd >> rsh) | (rt & ~(32'hFFFF_FFFF >> rsh));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_misalign(input logic [2:0] t, input logic [1:0] off);
        return ((t == 3'd3 || t == 3'd4) && off[0]) || (t == 3'd5 && off != 2'd0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input stim_t s);
        exp_t nxt;
        logic ll_next;
        @(negedge clk);
        rst                 = s.rst;
        bus.stall           = s.stall;
        bus.flush           = s.flush;
        bus.mem_wd          = s.wd;
        bus.mem_wreg        = s.wreg;
        bus.mem_wdata       = s.wdata;
        bus.mem_ld_type     = s.ld;
        bus.mem_ld_off      = s.off;
        bus.mem_rdata       = s.rdata;
        bus.mem_rt_old      = s.rt;
        bus.mem_whilo       = s.whilo;
        bus.mem_hi          = s.hi;
        bus.mem_lo          = s.lo;
        bus.mem_llbit_we    = s.llwe;
        bus.mem_llbit_value = s.llval;

        ll_next = (s.rst || s.flush) ? 1'b0 : (m.llwe ? m.llval : m_llbit);
        if (s.rst || s.flush || (s.stall[4] && !s.stall[5])) begin
            nxt = '0;
        end else if (!s.stall[4]) begin
            nxt.wd    = s.wd;
            nxt.wreg  = s.wreg && !ref_misalign(s.ld, s.off);
            nxt.wdata = (s.ld != 3'd0) ? ref_align(s.ld, s.off, s.rdata, s.rt) : s.wdata;
            nxt.dc    = ref_misalign(s.ld, s.off);
            nxt.whilo = s.whilo;
            nxt.hi    = s.hi;
            nxt.lo    = s.lo;
            nxt.llwe  = s.llwe;
            nxt.llval = s.llval;
            nxt.llo   = 1'b0;
        end else begin
            nxt = m;
        end
        m_llbit = ll_next;
        nxt.llo = nxt.llwe ? nxt.llval : m_llbit;
        m = nxt;
        sb.push_back(nxt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_wd",    32'(bus.wb_wd),    32'(e.wd));
                chk("wb_wreg",  32'(bus.wb_wreg),  32'(e.wreg));
                if (!e.dc) chk("wb_wdata", bus.wb_wdata, e.wdata);
                chk("wb_whilo", 32'(bus.wb_whilo), 32'(e.whilo));
                chk("wb_hi",    bus.wb_hi,         e.hi);
                chk("wb_lo",    bus.wb_lo,         e.lo);
                chk("llbit_o",  32'(bus.llbit_o),  32'(e.llo));
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 63) == 0);
        case ($urandom_range(0, 7))
            0:       s.stall = 6'b011111;
            1:       s.stall = 6'b111111;
            default: s.stall = 6'b000000;
        endcase
        s.flush = ($urandom_range(0, 15) == 0);
        s.wd    = 5'($urandom);
        s.wreg  = 1'($urandom);
        s.wdata = $urandom;
        s.ld    = 3'($urandom);
        s.off   = 2'($urandom);
        s.rdata = $urandom;
        s.rt    = $urandom;
        s.whilo = 1'($urandom);
        s.hi    = $urandom;
        s.lo    = $urandom;
        s.llwe  = ($urandom_range(0, 3) == 0);
        s.llval = 1'($urandom);
        return s;
    endfunction

    initial begin : stimulus
        stim_t s;
        m       = '0;
        m_llbit = 1'b0;
        rst     = 1'b1;
        bus.stall = '0;
        bus.flush = 1'b0;

        // Reset for two cycles with junk on the inputs.
        s = '0; s.rst = 1'b1; s.wd = 5'd7; s.wreg = 1'b1; s.whilo = 1'b1; s.llwe = 1'b1;
        drive(s); drive(s);

        // Plain pass-through.
        s = '0; s.wd = 5'd3; s.wreg = 1'b1; s.wdata = 32'h1234_5678;
        drive(s);

        // Loads from 0x8899AABB.
        s = '0; s.wreg = 1'b1; s.rdata = 32'h8899_AABB; s.rt = 32'h1122_3344; s.wdata = 32'hDEAD_BEEF;
        s.wd = 5'd4;  s.ld = 3'd1; s.off = 2'd1; drive(s);
        s.wd = 5'd5;  s.ld = 3'd2; s.off = 2'd1; drive(s);
        s.wd = 5'd6;  s.ld = 3'd3; s.off = 2'd2; drive(s);
        s.wd = 5'd7;  s.ld = 3'd6; s.off = 2'd2; drive(s);
        s.wd = 5'd8;  s.ld = 3'd7; s.off = 2'd1; drive(s);
        // Misaligned: write suppressed, other fields latched.
        s.wd = 5'd9;  s.ld = 3'd5; s.off = 2'd1; s.whilo = 1'b1; s.hi = 32'h55; drive(s);
        s.wd = 5'd10; s.ld = 3'd3; s.off = 2'd3; drive(s);
        s.whilo = 1'b0;

        // MEM stalled, WB free: bubble.
        s.wd = 5'd11; s.ld = 3'd0; s.whilo = 1'b1; s.stall = 6'b011111; drive(s);

        // Hold for three cycles, then the next instruction advances.
        s = '0; s.wd = 5'd12; s.wreg = 1'b1; s.wdata = 32'hCAFE_0001; s.whilo = 1'b1;
        s.hi = 32'h1; s.lo = 32'h2; drive(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 1'b0; s.flush = 1'b0; s.stall = 6'b111111; drive(s);
        end
        s = '0; s.wd = 5'd13; s.wreg = 1'b1; s.wdata = 32'hCAFE_0002; drive(s);

        // LL then flush: LL bit set, then cleared with a bubble.
        s = '0; s.wd = 5'd14; s.wreg = 1'b1; s.ld = 3'd5; s.rdata = 32'h0BAD_F00D;
        s.llwe = 1'b1; s.llval = 1'b1; drive(s);
        s = '0; s.wd = 5'd15; s.wreg = 1'b1; s.wdata = 32'h77; drive(s);
        s = '0; s.wd = 5'd16; s.wreg = 1'b1; s.whilo = 1'b1; s.hi = 32'h9; s.flush = 1'b1; drive(s);

        // Flush beats latch; then HI/LO write.
        s = '0; s.wd = 5'd17; s.wreg = 1'b1; s.wdata = 32'h88; s.flush = 1'b1; drive(s);
        s = '0; s.whilo = 1'b1; s.hi = 32'hA; s.lo = 32'hB; drive(s);

        // Reset while a held instruction sits in WB.
        s = '0; s.wd = 5'd18; s.wreg = 1'b1; s.wdata = 32'h99; s.llwe = 1'b1; s.llval = 1'b1; drive(s);
        s.stall = 6'b111111; drive(s);
        s.rst = 1'b1; drive(s);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            s = rand_stim();
            drive(s);
        end

        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
